// File: rtl/data_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_responder_pkg
// Shared definitions for the data-memory responder slice: default geometry of
// the data memory, the width of the wait-state counter and the FSM encoding
// used by the responder.
// -----------------------------------------------------------------------------
package data_memory_responder_pkg;

   // Width of the pipeline registers; the data memory uses it for both data
   // and byte addresses.
   localparam int REGISTER_LEN = 32;

   // Byte address that maps onto word 0, and number of words stored.
   localparam int DATA_MEM_BASE  = 1024;
   localparam int DATA_MEM_DEPTH = 64;

   // Wide enough for the largest legal wait-state count (15).
   localparam int COUNT_W = 4;

   // Responder FSM encoding.
   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/data_memory_responder_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Word storage behind the data-memory responder. Writes are synchronous,
// reads are combinational by word index, and an active-low reset clears every
// word asynchronously.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low; clears all words
//   write_en    commit write_data into the word at index on this edge
//   index       word index for both the read and the write
//   write_data  word to store
//   read_data   word currently stored at index
// -----------------------------------------------------------------------------
module data_mem_array #(
   parameter int WORD_LEN = 32,
   parameter int DEPTH    = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       write_en,
   input  logic [$clog2(DEPTH)-1:0]   index,
   input  logic [WORD_LEN-1:0]        write_data,
   output logic [WORD_LEN-1:0]        read_data
);

   logic [WORD_LEN-1:0] mem [DEPTH];

   // Storage: cleared as a whole on reset, otherwise one word per write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write_en) begin
         mem[index] <= write_data;
      end
   end

   assign read_data = mem[index];

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Memory end of the MEM-stage request/ready handshake. A request seen in IDLE
// is latched, held for WAIT_CYCLES busy cycles, committed on the last busy
// edge, and acknowledged with ready high for one DONE cycle. Accesses outside
// the mapped window take the same time but drop writes and return 0 on reads.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low; aborts any access in flight
//   address    byte address of the access (bits [1:0] ignored)
//   WriteData  store data
//   MemRead    load request
//   MemWrite   store request (wins if MemRead is also high)
//   ReadData   registered load result, held until the next read commits
//   ready      high when idle with no request or when an access completes
// -----------------------------------------------------------------------------
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int WORD_LEN    = REGISTER_LEN,
   parameter int DEPTH       = DATA_MEM_DEPTH,
   parameter int BASE_ADDR   = DATA_MEM_BASE,
   parameter int WAIT_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WORD_LEN-1:0] address,
   input  logic [WORD_LEN-1:0] WriteData,
   input  logic                MemRead,
   input  logic                MemWrite,
   output logic [WORD_LEN-1:0] ReadData,
   output logic                ready
);

   localparam int                 IDX_W      = $clog2(DEPTH);
   localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WAIT_CYCLES - 1);

   mem_state_t          state;
   logic [COUNT_W-1:0]  counter;
   logic [WORD_LEN-1:0] req_addr;
   logic [WORD_LEN-1:0] req_data;
   logic                req_write;

   logic [WORD_LEN-1:0] offset;
   logic [WORD_LEN-1:0] word_num;
   logic                in_range;
   logic                commit;
   logic                array_we;
   logic [WORD_LEN-1:0] array_rdata;

   // Address translation works on the latched address so that the inputs
   // are free to change while the access is in flight. The lower-bound test
   // is needed because the subtraction wraps for addresses below the window.
   assign offset   = req_addr - WORD_LEN'(BASE_ADDR);
   assign word_num = offset >> 2;
   assign in_range = (req_addr >= WORD_LEN'(BASE_ADDR)) &&
                     (word_num < WORD_LEN'(DEPTH));

   assign commit   = (state == MEM_BUSY) && (counter == LAST_COUNT);
   assign array_we = commit && req_write && in_range;

   data_mem_array #(
      .WORD_LEN (WORD_LEN),
      .DEPTH    (DEPTH)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .write_en   (array_we),
      .index      (word_num[IDX_W-1:0]),
      .write_data (req_data),
      .read_data  (array_rdata)
   );

   // Responder FSM: latch in IDLE, count wait states in BUSY, commit on the
   // final busy edge, then spend exactly one cycle in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= MEM_IDLE;
         counter   <= '0;
         ReadData  <= '0;
         req_addr  <= '0;
         req_data  <= '0;
         req_write <= 1'b0;
      end else begin
         case (state)
            MEM_IDLE: begin
               if (MemRead || MemWrite) begin
                  req_addr  <= address;
                  req_data  <= WriteData;
                  req_write <= MemWrite;
                  counter   <= '0;
                  state     <= MEM_BUSY;
               end
            end
            MEM_BUSY: begin
               counter <= counter + COUNT_W'(1);
               if (commit) begin
                  // Writes and combined read/write leave ReadData untouched.
                  if (!req_write) begin
                     ReadData <= in_range ? array_rdata : '0;
                  end
                  state <= MEM_DONE;
               end
            end
            MEM_DONE: begin
               state <= MEM_IDLE;
            end
            default: begin
               state <= MEM_IDLE;
            end
         endcase
      end
   end

   // Ready is forced high during reset so a stalled pipeline is released
   // immediately; in IDLE it drops as soon as a request appears.
   always_comb begin
      ready = 1'b1;
      if (rst) begin
         case (state)
            MEM_IDLE: ready = ~(MemRead | MemWrite);
            MEM_BUSY: ready = 1'b0;
            MEM_DONE: ready = 1'b1;
            default:  ready = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Directed bench for data_memory_responder with WAIT_CYCLES = 4. A word-level
// model of the memory predicts ReadData for every access; the prediction is
// queued when the request is driven and compared in the DONE cycle.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

   localparam int WAIT_CYCLES = 4;
   localparam int BASE        = 1024;
   localparam int DEPTH       = 64;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [31:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        ready;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   logic [31:0] model [DEPTH];
   logic [31:0] modelReadData;
   logic [31:0] expQ [$];

   data_memory_responder #(
      .WORD_LEN    (32),
      .DEPTH       (DEPTH),
      .BASE_ADDR   (BASE),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .address   (address),
      .WriteData (WriteData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .ReadData  (ReadData),
      .ready     (ready)
   );

   // 10-unit clock; inputs change 1 unit after posedge, outputs are sampled
   // on the negedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic inRange(input logic [31:0] a);
      return (a >= 32'(BASE)) && (((a - 32'(BASE)) >> 2) < 32'(DEPTH));
   endfunction

   function automatic logic [5:0] wordIndex(input logic [31:0] a);
      return 6'((a - 32'(BASE)) >> 2);
   endfunction

   // One complete access: predict, drive, then check ready every cycle and
   // ReadData in the DONE cycle. dropCycle > 0 removes the request in that
   // busy cycle.
   task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                input int dropCycle);
      if (wr) begin
         if (inRange(addr)) model[wordIndex(addr)] = data;
      end else if (rd) begin
         modelReadData = inRange(addr) ? model[wordIndex(addr)] : 32'h0;
      end
      expQ.push_back(modelReadData);

      @(posedge clk); #1;
      address   = addr;
      WriteData = data;
      MemRead   = rd;
      MemWrite  = wr;
      @(negedge clk);
      checkOutput($sformatf("%s ready c0", name), {31'b0, ready}, 32'h0);

      for (int c = 1; c <= WAIT_CYCLES; c++) begin
         @(posedge clk); #1;
         if (c == dropCycle) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
         end
         @(negedge clk);
         checkOutput($sformatf("%s ready c%0d", name, c), {31'b0, ready}, 32'h0);
      end

      @(posedge clk); #1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      address   = $urandom;
      WriteData = $urandom;
      @(negedge clk);
      checkOutput($sformatf("%s ready done", name), {31'b0, ready}, 32'h1);
      checkOutput($sformatf("%s ReadData", name), ReadData, expQ.pop_front());

      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("%s ready idle", name), {31'b0, ready}, 32'h1);
   endtask

   initial begin
      rst           = 1'b1;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      address       = 32'd1024;
      WriteData     = 32'h0;
      modelReadData = 32'h0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

      // Reset with a read request held: ready must still be high.
      #2;
      rst     = 1'b0;
      MemRead = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset ready", {31'b0, ready}, 32'h1);
      checkOutput("reset ReadData", ReadData, 32'h0);
      @(posedge clk); #1;
      MemRead = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      checkOutput("post-reset ready", {31'b0, ready}, 32'h1);
      checkOutput("post-reset ReadData", ReadData, 32'h0);

      applyStimulus("rd 1024 fresh", 1'b1, 1'b0, 32'd1024, 32'h0, 0);
      applyStimulus("wr 1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 0);
      applyStimulus("rd 1028", 1'b1, 1'b0, 32'd1028, 32'h0, 0);
      applyStimulus("rd 1030 low bits", 1'b1, 1'b0, 32'd1030, 32'h0, 0);

      // Out-of-range accesses on both sides of the window.
      applyStimulus("wr 1020 below", 1'b0, 1'b1, 32'd1020, 32'h12345678, 0);
      applyStimulus("wr 1280 above", 1'b0, 1'b1, 32'd1280, 32'h12345678, 0);
      applyStimulus("rd 1020 below", 1'b1, 1'b0, 32'd1020, 32'h0, 0);
      applyStimulus("rd 1024 word0", 1'b1, 1'b0, 32'd1024, 32'h0, 0);
      applyStimulus("rd 1028 kept", 1'b1, 1'b0, 32'd1028, 32'h0, 0);
      applyStimulus("rd 1280 above", 1'b1, 1'b0, 32'd1280, 32'h0, 0);

      // Last word of the window.
      applyStimulus("wr 1276 last", 1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, 0);
      applyStimulus("rd 1276 last", 1'b1, 1'b0, 32'd1276, 32'h0, 0);

      // Combined read+write acts as a write and keeps ReadData.
      applyStimulus("rdwr 1044", 1'b1, 1'b1, 32'd1044, 32'h00000077, 0);
      applyStimulus("rd 1044", 1'b1, 1'b0, 32'd1044, 32'h0, 0);

      // Request withdrawn in busy cycle 2 still completes.
      applyStimulus("wr 1032 dropped", 1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, 2);
      applyStimulus("rd 1032", 1'b1, 1'b0, 32'd1032, 32'h0, 0);

      // Reset in busy cycle 3 aborts the write and clears the memory.
      @(posedge clk); #1;
      address   = 32'd1040;
      WriteData = 32'h00000011;
      MemWrite  = 1'b1;
      @(negedge clk);
      checkOutput("abort ready c0", {31'b0, ready}, 32'h0);
      for (int c = 1; c <= 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("abort ready c%0d", c), {31'b0, ready}, 32'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("abort ready in reset", {31'b0, ready}, 32'h1);
      checkOutput("abort ReadData in reset", ReadData, 32'h0);
      MemWrite = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      modelReadData = 32'h0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort ready idle", {31'b0, ready}, 32'h1);

      applyStimulus("rd 1040 aborted", 1'b1, 1'b0, 32'd1040, 32'h0, 0);
      applyStimulus("rd 1028 cleared", 1'b1, 1'b0, 32'd1028, 32'h0, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
